// File: rtl/ring_buffer_leveled.sv
// rtl/ring_buffer_leveled.sv - single-clock FIFO with occupancy count and level flags.
// Define RING_BUFFER_ERR_FLAGS_EN to add clear_errors plus the sticky overflow/underflow flags.
module ring_buffer_leveled #(
   parameter int WordLengthBits       = 8,
   parameter int NumWords             = 128,
   parameter int AlmostFullThreshold  = 124,
   parameter int AlmostEmptyThreshold = 4
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               put,
   input  logic [WordLengthBits-1:0]          data_in,
   input  logic                               get,
   output logic [WordLengthBits-1:0]          data_out,
   output logic                               data_out_valid,
   output logic [$clog2(NumWords+1)-1:0]      word_count,
   output logic                               buffer_empty,
   output logic                               buffer_full,
   output logic                               buffer_almost_full,
   output logic                               buffer_almost_empty
`ifdef RING_BUFFER_ERR_FLAGS_EN
   ,
   input  logic                               clear_errors,
   output logic                               overflow,
   output logic                               underflow
`endif
);

   localparam int CountBits = $clog2(NumWords + 1);
   localparam int PtrBits   = ($clog2(NumWords) < 1) ? 1 : $clog2(NumWords);

   if (AlmostFullThreshold < 1 || AlmostFullThreshold > NumWords) begin : g_bad_af
      $error("AlmostFullThreshold must be in 1..NumWords");
   end
   if (AlmostEmptyThreshold < 0 || AlmostEmptyThreshold > NumWords - 1) begin : g_bad_ae
      $error("AlmostEmptyThreshold must be in 0..NumWords-1");
   end

   logic [WordLengthBits-1:0] mem [NumWords];
   logic [PtrBits-1:0]        head;
   logic [PtrBits-1:0]        tail;
   logic                      put_acc;
   logic                      get_acc;

   // Acceptance looks only at the registered flags, so a full FIFO still drains on put+get.
   assign put_acc = put & ~buffer_full;
   assign get_acc = get & ~buffer_empty;

   function automatic logic [PtrBits-1:0] next_ptr(input logic [PtrBits-1:0] p);
      return (p == PtrBits'(NumWords - 1)) ? '0 : p + PtrBits'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (put_acc) begin
         mem[head] <= data_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head           <= '0;
         tail           <= '0;
         word_count     <= '0;
         data_out       <= '0;
         data_out_valid <= 1'b0;
      end else begin
         data_out_valid <= get_acc;
         if (put_acc) begin
            head <= next_ptr(head);
         end
         if (get_acc) begin
            data_out <= mem[tail];
            tail     <= next_ptr(tail);
         end
         case ({put_acc, get_acc})
            2'b10:   word_count <= word_count + CountBits'(1);
            2'b01:   word_count <= word_count - CountBits'(1);
            default: word_count <= word_count;
         endcase
      end
   end

   assign buffer_empty        = (word_count == '0);
   assign buffer_full         = (word_count == CountBits'(NumWords));
   assign buffer_almost_full  = (word_count >= CountBits'(AlmostFullThreshold));
   assign buffer_almost_empty = (word_count <= CountBits'(AlmostEmptyThreshold));

`ifdef RING_BUFFER_ERR_FLAGS_EN
   // A new error in the same cycle as clear_errors must not be lost, so set wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (put & buffer_full) begin
            overflow <= 1'b1;
         end else if (clear_errors) begin
            overflow <= 1'b0;
         end
         if (get & buffer_empty) begin
            underflow <= 1'b1;
         end else if (clear_errors) begin
            underflow <= 1'b0;
         end
      end
   end
`endif

endmodule

// File: tb/tb_ring_buffer_leveled.sv
// tb/tb_ring_buffer_leveled.sv - vector table, corner sequences and queue-model random test.
module tb_ring_buffer_leveled;

   localparam int W  = 8;
   localparam int N  = 5;
   localparam int AF = 4;
   localparam int AE = 1;
   localparam int CW = $clog2(N + 1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          put = 1'b0;
   logic          get = 1'b0;
   logic [W-1:0]  data_in = '0;
   logic [W-1:0]  data_out;
   logic          data_out_valid;
   logic [CW-1:0] word_count;
   logic          buffer_empty;
   logic          buffer_full;
   logic          buffer_almost_full;
   logic          buffer_almost_empty;
`ifdef RING_BUFFER_ERR_FLAGS_EN
   logic          clear_errors = 1'b0;
   logic          overflow;
   logic          underflow;
`endif

   ring_buffer_leveled #(
      .WordLengthBits(W), .NumWords(N),
      .AlmostFullThreshold(AF), .AlmostEmptyThreshold(AE)
   ) dut (
      .clk(clk), .rst_n(rst_n), .put(put), .data_in(data_in), .get(get),
      .data_out(data_out), .data_out_valid(data_out_valid), .word_count(word_count),
      .buffer_empty(buffer_empty), .buffer_full(buffer_full),
      .buffer_almost_full(buffer_almost_full), .buffer_almost_empty(buffer_almost_empty)
`ifdef RING_BUFFER_ERR_FLAGS_EN
      , .clear_errors(clear_errors), .overflow(overflow), .underflow(underflow)
`endif
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: a plain queue of stored words plus the last word read out.
   logic [W-1:0] q[$];
   logic [W-1:0] m_dout;
   logic         m_valid;
   logic         m_ovf;
   logic         m_unf;

   task automatic check_model(input string tag);
      int n;
      n = q.size();
      check({tag, " count"}, 32'(word_count), 32'(n));
      check({tag, " valid"}, 32'(data_out_valid), 32'(m_valid));
      check({tag, " data_out"}, 32'(data_out), 32'(m_dout));
      check({tag, " empty"}, 32'(buffer_empty), 32'(n == 0));
      check({tag, " full"}, 32'(buffer_full), 32'(n == N));
      check({tag, " almost_full"}, 32'(buffer_almost_full), 32'(n >= AF));
      check({tag, " almost_empty"}, 32'(buffer_almost_empty), 32'(n <= AE));
`ifdef RING_BUFFER_ERR_FLAGS_EN
      check({tag, " overflow"}, 32'(overflow), 32'(m_ovf));
      check({tag, " underflow"}, 32'(underflow), 32'(m_unf));
`endif
   endtask

   // Called at a negedge; applies one cycle of stimulus and checks at the next negedge.
   task automatic step(input logic p, input logic g, input logic [W-1:0] d, input logic clr,
                       input string tag);
      bit was_full, was_empty;
      put = p; get = g; data_in = d;
`ifdef RING_BUFFER_ERR_FLAGS_EN
      clear_errors = clr;
`endif
      was_full  = (q.size() == N);
      was_empty = (q.size() == 0);
      m_valid = g && !was_empty;
      if (m_valid) m_dout = q.pop_front();
      if (p && !was_full) q.push_back(d);
      if (clr) begin
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end
      if (p && was_full) m_ovf = 1'b1;
      if (g && was_empty) m_unf = 1'b1;
      @(posedge clk);
      @(negedge clk);
      put = 1'b0; get = 1'b0;
`ifdef RING_BUFFER_ERR_FLAGS_EN
      clear_errors = 1'b0;
`endif
      check_model(tag);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      q.delete();
      m_dout = '0; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic         p;
      logic         g;
      logic [W-1:0] d;
      int           cnt;
      logic         v;
      logic [W-1:0] dout;
   } vec_t;

   function automatic vec_t mk(logic p, logic g, logic [W-1:0] d, int cnt, logic v,
                               logic [W-1:0] dout);
      vec_t r;
      r.p = p; r.g = g; r.d = d; r.cnt = cnt; r.v = v; r.dout = dout;
      return r;
   endfunction

   vec_t vecs[$];

   initial begin
      // Fill/drain, 6th put on full, idle hold, put+get on empty/full/mid, get on empty.
      vecs.push_back(mk(1, 0, 8'h11, 1, 0, 8'h00));
      vecs.push_back(mk(1, 0, 8'h12, 2, 0, 8'h00));
      vecs.push_back(mk(1, 0, 8'h13, 3, 0, 8'h00));
      vecs.push_back(mk(1, 0, 8'h14, 4, 0, 8'h00));
      vecs.push_back(mk(1, 0, 8'h15, 5, 0, 8'h00));
      vecs.push_back(mk(1, 0, 8'h99, 5, 0, 8'h00));
      vecs.push_back(mk(0, 1, 8'h00, 4, 1, 8'h11));
      vecs.push_back(mk(0, 1, 8'h00, 3, 1, 8'h12));
      vecs.push_back(mk(0, 1, 8'h00, 2, 1, 8'h13));
      vecs.push_back(mk(0, 1, 8'h00, 1, 1, 8'h14));
      vecs.push_back(mk(0, 1, 8'h00, 0, 1, 8'h15));
      vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h15));
      vecs.push_back(mk(1, 1, 8'h21, 1, 0, 8'h15));
      vecs.push_back(mk(1, 0, 8'h22, 2, 0, 8'h15));
      vecs.push_back(mk(1, 0, 8'h23, 3, 0, 8'h15));
      vecs.push_back(mk(1, 0, 8'h24, 4, 0, 8'h15));
      vecs.push_back(mk(1, 0, 8'h25, 5, 0, 8'h15));
      vecs.push_back(mk(1, 1, 8'h26, 4, 1, 8'h21));
      vecs.push_back(mk(1, 1, 8'h27, 4, 1, 8'h22));
      vecs.push_back(mk(0, 1, 8'h00, 3, 1, 8'h23));
      vecs.push_back(mk(0, 1, 8'h00, 2, 1, 8'h24));
      vecs.push_back(mk(0, 1, 8'h00, 1, 1, 8'h25));
      vecs.push_back(mk(0, 1, 8'h00, 0, 1, 8'h27));
      vecs.push_back(mk(0, 1, 8'h00, 0, 0, 8'h27));

      do_reset();
      check("reset count", 32'(word_count), 32'd0);
      check("reset empty", 32'(buffer_empty), 32'd1);
      check("reset almost_empty", 32'(buffer_almost_empty), 32'd1);
      check("reset full", 32'(buffer_full), 32'd0);
      check("reset valid", 32'(data_out_valid), 32'd0);

      foreach (vecs[i]) begin
         put = vecs[i].p; get = vecs[i].g; data_in = vecs[i].d;
         @(posedge clk);
         @(negedge clk);
         put = 1'b0; get = 1'b0;
         check($sformatf("vec%0d count", i), 32'(word_count), 32'(vecs[i].cnt));
         check($sformatf("vec%0d valid", i), 32'(data_out_valid), 32'(vecs[i].v));
         check($sformatf("vec%0d data_out", i), 32'(data_out), 32'(vecs[i].dout));
         check($sformatf("vec%0d empty", i), 32'(buffer_empty), 32'(vecs[i].cnt == 0));
         check($sformatf("vec%0d full", i), 32'(buffer_full), 32'(vecs[i].cnt == N));
         check($sformatf("vec%0d almost_full", i), 32'(buffer_almost_full), 32'(vecs[i].cnt >= AF));
         check($sformatf("vec%0d almost_empty", i), 32'(buffer_almost_empty), 32'(vecs[i].cnt <= AE));
      end

      // Mid-stream asynchronous reset with 5 words stored.
      do_reset();
      for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h40 + i), 0, "pre-reset fill");
      step(0, 1, 8'h00, 0, "pre-reset get");
      step(1, 0, 8'h50, 0, "pre-reset refill");
      rst_n = 1'b0;
      #1;
      check("async reset count", 32'(word_count), 32'd0);
      check("async reset data_out", 32'(data_out), 32'd0);
      check("async reset valid", 32'(data_out_valid), 32'd0);
      check("async reset empty", 32'(buffer_empty), 32'd1);
      check("async reset full", 32'(buffer_full), 32'd0);
      check("async reset almost_full", 32'(buffer_almost_full), 32'd0);
      q.delete();
      m_dout = '0; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step(0, 1, 8'h00, 0, "post-reset get");

      // Wrap: 4 rounds of 3 puts and 3 gets, values 1..12.
      do_reset();
      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < 3; k++) step(1, 0, 8'(r * 3 + k + 1), 0, "wrap put");
         for (int k = 0; k < 3; k++) begin
            step(0, 1, 8'h00, 0, "wrap get");
            check("wrap order", 32'(data_out), 32'(r * 3 + k + 1));
         end
      end
      check("wrap final count", 32'(word_count), 32'd0);

`ifdef RING_BUFFER_ERR_FLAGS_EN
      do_reset();
      step(0, 1, 8'h00, 0, "underflow set");
      check("underflow sticky", 32'(underflow), 32'd1);
      step(0, 0, 8'h00, 0, "underflow hold");
      for (int i = 0; i < 5; i++) step(1, 0, 8'(i), 0, "err fill");
      step(1, 0, 8'hAA, 0, "overflow set");
      check("overflow sticky", 32'(overflow), 32'd1);
      step(1, 0, 8'hAB, 1, "set beats clear");
      check("overflow set wins", 32'(overflow), 32'd1);
      check("underflow cleared", 32'(underflow), 32'd0);
      step(0, 0, 8'h00, 1, "clear both");
      check("overflow cleared", 32'(overflow), 32'd0);
`endif

      // Randomized traffic against the queue model, biased to visit full and empty.
      do_reset();
      for (int i = 0; i < 600; i++) begin
         logic p, g, c;
         int bias;
         bias = ((i / 60) % 2 == 0) ? 70 : 30;
         p = ($urandom_range(0, 99) < bias);
         g = ($urandom_range(0, 99) < 100 - bias);
         c = ($urandom_range(0, 15) == 0);
         step(p, g, 8'($urandom), c, $sformatf("rand%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
